// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice reused LSB-first over WIDTH clocks.
// Optional subtract mode (extra 'sub' input) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic             carry_reg;
  logic [WIDTH-2:0] res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  // Shared slice: two half adders with their carries ORed
  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next;
  logic [WIDTH-1:0] res_next;

  assign ha1_s      = a_sh_reg[0] ^ b_sh_reg[0];
  assign ha1_c      = a_sh_reg[0] & b_sh_reg[0];
  assign ha2_s      = ha1_s ^ carry_reg;
  assign ha2_c      = ha1_s & carry_reg;
  assign carry_next = ha1_c | ha2_c;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB
  assign res_next   = {ha2_s, res_reg};

  logic [WIDTH-1:0] b_load;
  logic             c_load;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      carry_reg <= 1'b0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b_load;
            carry_reg <= c_load;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          carry_reg <= carry_next;
          res_reg   <= res_next[WIDTH-1:1];
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum_reg   <= res_next;
            cout_reg  <= carry_next;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=4): latency, back-to-back, ignored start,
// mid-run reset, full operand sweep against a+b+cin; subtract cases with SERIAL_ADDER_SUB_EN.
module tb_serial_adder_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble inputs to show they are not reused
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] es, input logic ec);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, W);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    $display("op %s: sum=%0d cout=%0d cycles=%0d", tag, sum, cout, n);
  endtask

  initial begin
    int pulses;
    logic [W:0] model;

    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    // 2. 5+3
    start_op(4'd5, 4'd3, 1'b0, 1'b0);
    check("add53_busy", busy, 1);
    finish_op("add53", 4'd8, 1'b0);
    @(posedge clk); #1;
    check("add53_done_drop", done, 0);
    check("add53_idle", busy, 0);
    check("add53_hold", sum, 8);

    // 3. 15+1+1, then back-to-back 2+2 issued in the DONE cycle
    start_op(4'd15, 4'd1, 1'b1, 1'b0);
    finish_op("add15_1_1", 4'd1, 1'b1);
    start_op(4'd2, 4'd2, 1'b0, 1'b0);
    check("b2b_busy", busy, 1);
    finish_op("b2b22", 4'd4, 1'b0);
    @(posedge clk); #1;

    // 4. start while busy is ignored
    a = 4'd6; b = 4'd6; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1; start = 1'b1;
    check("ign_busy", busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        check("ign_sum", sum, 12);
        check("ign_cout", cout, 0);
      end
      @(posedge clk); #1;
    end
    check("ign_pulses", pulses, 1);
    $display("op ignore: sum=%0d cout=%0d pulses=%0d", sum, cout, pulses);

    // 5. reset during the second RUN cycle
    start_op(4'd9, 4'd9, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("abort_nodone", pulses, 0);
    $display("op abort: sum=%0d cout=%0d", sum, cout);
    start_op(4'd9, 4'd9, 1'b0, 1'b0);
    finish_op("add99", 4'd2, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    // 6. subtract mode
    start_op(4'd3, 4'd5, 1'b0, 1'b1);
    finish_op("sub35", 4'd14, 1'b0);
    start_op(4'd5, 4'd3, 1'b1, 1'b1);
    finish_op("sub53", 4'd2, 1'b1);
`endif

    // Full operand sweep, back-to-back
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          model = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
          start_op(W'(ia), W'(ib), 1'(ic), 1'b0);
          finish_op($sformatf("sw_%0d_%0d_%0d", ia, ib, ic), model[W-1:0], model[W]);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
